// File: rtl/var_write_tracer.sv
// Maps snooped data-memory writes back to microcode variable numbers and queues them as trace events.
// Write to FIFO head takes 2 cycles. When the FIFO is full and not popping, an event is dropped and ovf_count saturates.
module var_write_tracer #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic [ADDR_W-1:0]      FP,
    input  logic [ADDR_W-1:0]      GP,
    output logic                   ev_valid,
    input  logic                   ev_ready,
    output logic [7:0]             ev_var,
    output logic                   ev_local,
    output logic [DATA_W-1:0]      ev_data,
    output logic [$clog2(DEPTH):0] level,
    output logic [7:0]             ovf_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int HALF_W = ADDR_W - 1;
    localparam int ENT_W = 8 + 1 + DATA_W;
    localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(DEPTH);
    localparam logic [HALF_W-1:0] LOCAL_MAX = HALF_W'(14);
    localparam logic [HALF_W-1:0] GLOBAL_MAX = HALF_W'(239);

    logic              s1_valid;
    logic [ADDR_W-1:0] s1_addr, s1_fp, s1_gp;
    logic [DATA_W-1:0] s1_data;

    logic [ADDR_W-1:0] off_f, off_g;
    logic [HALF_W-1:0] half_f, half_g;
    logic              hit_l, hit_g, s2_match;
    logic [ENT_W-1:0]  s2_ent;

    logic [ENT_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic              push, pop;

    // Decode with the pointers captured alongside the address; the >= tests reject wrap-around offsets.
    always_comb begin
        off_f  = s1_addr - s1_fp;
        off_g  = s1_addr - s1_gp;
        half_f = off_f[ADDR_W-1:1];
        half_g = off_g[ADDR_W-1:1];
        hit_l  = (s1_addr >= s1_fp) && !off_f[0] && (half_f <= LOCAL_MAX);
        hit_g  = (s1_addr >= s1_gp) && !off_g[0] && (half_g <= GLOBAL_MAX);
        s2_match = s1_valid && (hit_l || hit_g);
        if (hit_l) begin
            s2_ent = {8'(half_f) + 8'd1, 1'b1, s1_data};
        end else begin
            s2_ent = {8'h10 + 8'(half_g), 1'b0, s1_data};
        end
    end

    assign ev_valid = (level != '0);
    assign pop      = ev_valid && ev_ready;
    assign push     = s2_match && ((level != FULL_LVL) || pop);
    assign {ev_var, ev_local, ev_data} = ev_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_addr   <= '0;
            s1_fp     <= '0;
            s1_gp     <= '0;
            s1_data   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            ovf_count <= '0;
        end else begin
            s1_valid <= en && wr_en;
            if (en && wr_en) begin
                s1_addr <= wr_addr;
                s1_fp   <= FP;
                s1_gp   <= GP;
                s1_data <= wr_data;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end else if (s2_match && ovf_count != 8'hFF) begin
                ovf_count <= ovf_count + 8'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s2_ent;
        end
    end
endmodule
